ebpf_lsh_iter_64bit: RTL and testbench

//  Multi-cycle 64-bit logical left shifter for the eBPF core ALU (BPF_LSH, ALU64 and ALU32).

---
 rtl/ebpf_lsh_iter_64bit.sv | 80 ++++++++
 tb/tb_ebpf_lsh_iter_64bit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ebpf_lsh_iter_64bit.sv
// ebpf_lsh_iter_64bit: multi-cycle 64-bit logical left shifter (eBPF BPF_LSH, ALU64/ALU32)
//   clk, rst              : core clock, asynchronous active-high reset
//   in_valid/in_ready     : operand handshake; in_a = value, in_b = shift amount, in_alu32 = 32-bit mode
//   out_valid/out_ready   : result handshake; out_c = shifted result (0 when no result is presented)
//   busy                  : an operation is in flight or its result is awaiting handoff
//   STEP bits are shifted per cycle so no full 64-bit barrel sits on the critical path.
module ebpf_lsh_iter_64bit #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_alu32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_c,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] STEP_W = 7'(STEP);
  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [6:0]  rem_q, rem_d;
  logic        alu32_q, alu32_d;
  logic [6:0]  shamt;
  logic        big;
  logic        in_ready_q, out_valid_q, busy_q;
  logic [63:0] out_c_q;
  // eBPF masks the shift amount to the operand width
  assign shamt = in_alu32 ? {2'b0, in_b[4:0]} : {1'b0, in_b[5:0]};
  assign big   = rem_q >= STEP_W;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    alu32_d = alu32_q;
    if (state_q == IDLE && in_valid) begin
      acc_d   = in_alu32 ? {32'h0, in_a[31:0]} : in_a;
      rem_d   = shamt;
      alu32_d = in_alu32;
      state_d = (shamt == 7'd0) ? DONE : SHIFT;
    end else if (state_q == SHIFT) begin
      // final partial step consumes whatever remains below STEP
      acc_d   = big ? acc_q << STEP_W : acc_q << rem_q;
      rem_d   = big ? rem_q - STEP_W : 7'd0;
      state_d = (rem_d == 7'd0) ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // outputs are registered from the next-state values so they line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      alu32_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      alu32_q     <= alu32_d;
      in_ready_q  <= state_d == IDLE;
      out_valid_q <= state_d == DONE;
      busy_q      <= state_d != IDLE;
      out_c_q     <= (state_d == DONE) ? (alu32_d ? {32'h0, acc_d[31:0]} : acc_d) : '0;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_c     = out_c_q;
endmodule

// File: tb/tb_ebpf_lsh_iter_64bit.sv
// tb_ebpf_lsh_iter_64bit: directed + random bench for the iterative left shifter
module tb_ebpf_lsh_iter_64bit;
  localparam int STEP = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_alu32 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_c;
  logic        busy;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];
  ebpf_lsh_iter_64bit #(.STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_alu32(in_alu32), .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic alu32);
    logic [63:0] r;
    r = alu32 ? ({32'h0, a[31:0]} << b[4:0]) : (a << b[5:0]);
    return alu32 ? {32'h0, r[31:0]} : r;
  endfunction
  function automatic int lat_of(input logic [63:0] b, input logic alu32);
    int s;
    s = alu32 ? int'(b[4:0]) : int'(b[5:0]);
    return (s + STEP - 1) / STEP + 1;
  endfunction
  // full operation: accept, count edges to out_valid, hand off, check idle afterwards
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic alu32);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      step;
      k++;
    end
    chk({tag, "_rdy"}, {63'b0, in_ready}, 64'd1);
    sb.push_back(model(a, b, alu32));
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_alu32 = alu32;
    step;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin
      chk({tag, "_ready_low"}, {63'b0, in_ready}, 64'd0);
      step;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat_of(b, alu32)));
    chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
    out_ready = 1'b1;
    chk({tag, "_out_c"}, out_c, sb.pop_front());
    step;
    out_ready = 1'b0;
    chk({tag, "_valid_after"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_c_after"}, out_c, 64'd0);
    chk({tag, "_rdy_after"}, {63'b0, in_ready}, 64'd1);
  endtask
  initial begin
    logic [63:0] held;
    int k;
    #12;
    chk("rst_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_c", out_c, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    step;
    rst = 1'b0;
    step;
    run_op("t1", 64'h1, 64'd63, 1'b0);
    run_op("t2", 64'hFFFF_FFFF_0000_0001, 64'h21, 1'b1);
    run_op("t3", 64'hDEAD_BEEF_0000_1234, 64'd64, 1'b0);
    run_op("t4", 64'h3, 64'd9, 1'b0);
    run_op("a32_31", 64'h0000_0000_0000_0003, 64'd31, 1'b1);
    run_op("a64_8", 64'hFF00_0000_0000_00FF, 64'd8, 1'b0);
    run_op("a64_16", 64'h1234_5678_9ABC_DEF0, 64'h7FFF_FFC0_0000_0010, 1'b0);
    // T5: backpressure in DONE, extra in_valid must be ignored
    sb.push_back(model(64'hA5, 64'd4, 1'b0));
    in_valid = 1'b1;
    in_a = 64'hA5;
    in_b = 64'd4;
    in_alu32 = 1'b0;
    step;
    in_a = 64'h7;
    in_b = 64'd1;
    k = 1;
    while (!out_valid && k < 100) begin
      step;
      k++;
    end
    chk("t5_latency", 64'(k), 64'd2);
    held = out_c;
    chk("t5_value", held, 64'hA50);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("t5_hold_valid", {63'b0, out_valid}, 64'd1);
      chk("t5_hold_c", out_c, held);
      chk("t5_hold_ready", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    chk("t5_out_c", out_c, sb.pop_front());
    step;
    out_ready = 1'b0;
    chk("t5_idle_valid", {63'b0, out_valid}, 64'd0);
    chk("t5_idle_ready", {63'b0, in_ready}, 64'd1);
    chk("t5_idle_busy", {63'b0, busy}, 64'd0);
    sb.push_back(model(64'h7, 64'd1, 1'b0));
    step;
    in_valid = 1'b0;
    chk("t5_second_busy", {63'b0, busy}, 64'd1);
    k = 1;
    while (!out_valid && k < 100) begin
      step;
      k++;
    end
    chk("t5_second_latency", 64'(k), 64'd2);
    out_ready = 1'b1;
    chk("t5_second_c", out_c, sb.pop_front());
    step;
    out_ready = 1'b0;
    // T6: reset in the middle of a shift
    in_valid = 1'b1;
    in_a = 64'h1;
    in_b = 64'd40;
    in_alu32 = 1'b0;
    step;
    in_valid = 1'b0;
    step;
    chk("t6_shifting", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("t6_rst_ready", {63'b0, in_ready}, 64'd1);
    chk("t6_rst_busy", {63'b0, busy}, 64'd0);
    chk("t6_rst_c", out_c, 64'd0);
    step;
    rst = 1'b0;
    step;
    run_op("t6_next", 64'h5, 64'd2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
